// File: rtl/step_gen_ramp.sv
// Step/direction pulse generator: a velocity ramp feeds a phase accumulator whose carries become step pulses.
// Macro STEP_GEN_RAMP_ACCEL_EN enables the acceleration ramp; without it cur_vel follows target_vel one cycle late.
module step_gen_ramp #(
   parameter int W         = 32,
   parameter int STEP_HIGH = 4,
   parameter int STEP_LOW  = 4,
   parameter int DIR_SETUP = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic signed [W-1:0] target_vel,
   input  logic        [W-1:0] accel,
   input  logic                pos_load,
   input  logic signed [W-1:0] pos_load_val,
   output logic                step,
   output logic                dir,
   output logic signed [W-1:0] position,
   output logic signed [W-1:0] cur_vel,
   output logic                busy,
   output logic                overrun,
   output logic        [1:0]   dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_HIGH = 2'd2, S_LOW = 2'd3} state_t;

   localparam int CMAX = (DIR_SETUP > STEP_HIGH) ? ((DIR_SETUP > STEP_LOW) ? DIR_SETUP : STEP_LOW)
                                                 : ((STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW);
   localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

   state_t              r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt;
   logic signed [W-1:0] r_cur_vel, w_vel_next, r_position;
   logic [W-1:0]        r_acc, w_abs;
   logic [W:0]          w_sum;
   logic                r_req, r_req_dir;
   logic                r_pend, r_pend_dir, w_pend_nxt, w_pend_dir_nxt;
   logic                r_dir, w_dir_nxt, r_overrun, w_ovr_nxt;
   logic                w_free, w_have, w_sel_dir, w_enter_high;

`ifdef STEP_GEN_RAMP_ACCEL_EN
   // Two guard bits keep cur_vel +/- accel exact so the clamp to target never sees a wrapped value.
   localparam int EW = W + 2;
   logic signed [EW-1:0] w_vel_x, w_tgt_x, w_up, w_dn;
   assign w_vel_x = {{2{r_cur_vel[W-1]}}, r_cur_vel};
   assign w_tgt_x = {{2{target_vel[W-1]}}, target_vel};
   assign w_up    = w_vel_x + {2'b00, accel};
   assign w_dn    = w_vel_x - {2'b00, accel};

   always_comb begin
      w_vel_next = r_cur_vel;
      if (w_vel_x < w_tgt_x)
         w_vel_next = (w_up > w_tgt_x) ? target_vel : w_up[W-1:0];
      else if (w_vel_x > w_tgt_x)
         w_vel_next = (w_dn < w_tgt_x) ? target_vel : w_dn[W-1:0];
   end
`else
   logic w_unused_accel;
   assign w_unused_accel = ^accel;
   assign w_vel_next     = target_vel;
`endif

   // Magnitude of the most negative value is 2^(W-1), which is exact as an unsigned W-bit number.
   assign w_abs = r_cur_vel[W-1] ? (~r_cur_vel + W'(1)) : r_cur_vel;
   assign w_sum = {1'b0, r_acc} + {1'b0, w_abs};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_cur_vel <= '0;
         r_req     <= 1'b0;
         r_req_dir <= 1'b1;
      end else if (enable) begin
         r_acc     <= w_sum[W-1:0];
         r_cur_vel <= w_vel_next;
         r_req     <= w_sum[W];
         r_req_dir <= ~r_cur_vel[W-1];
      end else begin
         r_req     <= 1'b0;
      end
   end

   // Request handshake: r_req is a one-cycle valid with no ready. It is always consumed that cycle:
   // taken by the FSM when free, parked in the one-deep slot when busy, or dropped (overrun) when the slot is full.
   // "Free" includes the last LOW cycle so back-to-back pulses need no idle gap.
   assign w_free    = (r_state == S_IDLE) || ((r_state == S_LOW) && (r_cnt == '0));
   assign w_have    = r_pend | r_req;
   assign w_sel_dir = r_pend ? r_pend_dir : r_req_dir;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_dir_nxt      = r_dir;
      w_pend_nxt     = r_pend;
      w_pend_dir_nxt = r_pend_dir;
      w_ovr_nxt      = r_overrun;
      w_enter_high   = 1'b0;
      case (r_state)
         S_SETUP: begin
            if (r_cnt == '0) begin
               w_state_nxt  = S_HIGH;
               w_cnt_nxt    = CW'(STEP_HIGH - 1);
               w_enter_high = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_HIGH: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = CW'(STEP_LOW - 1);
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_LOW: begin
            if (r_cnt == '0) w_state_nxt = S_IDLE;
            else             w_cnt_nxt   = r_cnt - CW'(1);
         end
         default: ;
      endcase
      if (w_free && w_have) begin
         if (w_sel_dir == r_dir) begin
            w_state_nxt  = S_HIGH;
            w_cnt_nxt    = CW'(STEP_HIGH - 1);
            w_enter_high = 1'b1;
         end else begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = CW'(DIR_SETUP - 1);
            w_dir_nxt   = ~r_dir;
         end
         w_pend_nxt     = r_pend & r_req;
         w_pend_dir_nxt = r_req_dir;
      end else if (!w_free && r_req) begin
         if (r_pend) begin
            w_ovr_nxt = 1'b1;
         end else begin
            w_pend_nxt     = 1'b1;
            w_pend_dir_nxt = r_req_dir;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_dir      <= 1'b1;
         r_pend     <= 1'b0;
         r_pend_dir <= 1'b1;
         r_overrun  <= 1'b0;
         r_position <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_dir      <= w_dir_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_dir <= w_pend_dir_nxt;
         r_overrun  <= w_ovr_nxt;
         if (pos_load)
            r_position <= pos_load_val;
         else if (w_enter_high)
            r_position <= r_dir ? (r_position + W'(1)) : (r_position - W'(1));
      end
   end

   assign step      = (r_state == S_HIGH);
   assign busy      = (r_state != S_IDLE);
   assign dir       = r_dir;
   assign position  = r_position;
   assign cur_vel   = r_cur_vel;
   assign overrun   = r_overrun;
   assign dbg_state = r_state;

endmodule
